ppu_vblank_dma: RTL and testbench
=================================

// Module: ppu_vblank_dma
// PURPOSE
//  Bus initiator that drives the PPU's CPU-side write port (address/write_data/write/chipselect).
//  Copies a block of 32-bit words from a local source RAM into PPU address space (OAM, palettes,
//  tile buffer/graphics), issuing writes only while the PPU irq (vblank) is high.
//  Sits between the host command logic and ppu_top, replacing per-word CPU pokes with one command.
// PARAMETERS
//  SRC_AW  9   source RAM word-address width
//  LEN_W   12  transfer-length width in words (max 2**LEN_W-1)
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-high reset
//  cmd_valid   in   1       command offered
//  cmd_ready   out  1       command accepted when cmd_valid&cmd_ready
//  cmd_src     in   SRC_AW  first source word address
//  cmd_dst     in   12      first PPU word address
//  cmd_len     in   LEN_W   number of words
//  irq         in   1       PPU vblank level (high = safe to write)
//  src_rd      out  1       source RAM read strobe
//  src_addr    out  SRC_AW  source RAM address
//  src_rdata   in   32      source data, valid exactly 1 cycle after src_rd
//  address     out  12      PPU write address
//  write_data  out  32      PPU write data
//  write       out  1       PPU write strobe
//  chipselect  out  1       PPU select (== write)
//  busy        out  1       command in progress
//  done        out  1       1-cycle pulse, last word written or zero-length completed
//  err         out  1       1-cycle pulse, command rejected
// BEHAVIOUR
//  Reset: cmd_ready=1, busy/done/err/write/chipselect/src_rd=0, address/write_data/src_addr=0,
//   FIFO emptied, in-flight read discarded, irq_q=0. Reset mid-transfer aborts with no done pulse.
//  States: IDLE -> ARM -> RUN -> IDLE. cmd_ready=1 only in IDLE; busy=1 in ARM/RUN.
//  IDLE, accept: if cmd_dst+cmd_len > 4096 (13-bit sum) -> err pulse next cycle, stay IDLE.
//   else if cmd_len==0 -> done pulse next cycle, stay IDLE. else latch src/dst/len, go ARM.
//  ARM: wait for irq rising edge (irq & ~irq_q); in that same cycle go RUN, first src_rd issued.
//   Never starts in the tail of a vblank already in progress.
//  RUN datapath: 2-entry FIFO of read data; counters rd_left, wr_left (init len).
//   src_rd=1 when irq & rd_left>0 & (occ + inflight - pop) < 2; src_addr increments per read.
//   src_rdata pushed into FIFO the cycle after src_rd, regardless of irq.
//   write=chipselect=1 when irq & occ>0; pops head; address = dst + words written so far.
//   Steady state 1 word/cycle; first write 2 cycles after first src_rd.
//  irq falls during RUN: reads and writes stop immediately; buffered data (<=2 words) held;
//   resume on any cycle irq is high again (no rising edge needed). No write ever with irq=0.
//  Completion: cycle after final write, done=1 for 1 cycle, state IDLE, busy=0.
//  cmd_valid while busy is ignored (cmd_ready=0). Address arithmetic 12-bit, never wraps
//   (guaranteed by the accept check). write_data/address hold last value when write=0.
// TESTING
//  len=4, src=0x10 (data A0..A3), dst=0x200, irq rises -> writes 0x200..0x203 = A0..A3 on
//   consecutive cycles, first 2 cycles after rise; done 1 cycle after last write.
//  irq already high at accept -> no write until irq falls and rises again.
//  len=8, irq drops after 3 writes for 20 cycles -> 0 writes while low, words 3..7 in order after.
//  dst=0xFFE, len=3 -> err pulse, no src_rd/write; dst=0xFFD, len=3 -> accepted, last addr 0xFFF.
//  len=0 -> done pulse next cycle, no bus activity; cmd_valid during busy -> ignored.
//  reset asserted mid-RUN -> next cycle write=0, busy=0, cmd_ready=1, no done; new cmd works.

Source files
------------

// File: rtl/ppu_vblank_dma_if.sv
// PPU CPU-side write port, with the vblank irq level the initiator watches.
// The DMA engine is the master; the PPU register file is the slave.
interface ppu_vblank_dma_if;
    logic [11:0] address;
    logic [31:0] write_data;
    logic        write;
    logic        chipselect;
    logic        irq;

    modport master (
        output address,
        output write_data,
        output write,
        output chipselect,
        input  irq
    );

    modport slave (
        input  address,
        input  write_data,
        input  write,
        input  chipselect,
        output irq
    );
endinterface

// File: rtl/ppu_vblank_dma.sv
// Vblank-gated block copy from a local source RAM into PPU address space.
// Reads run ahead into a 2-entry FIFO; PPU writes are issued only while irq is high.
module ppu_vblank_dma #(
    parameter int SRC_AW = 9,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SRC_AW-1:0] cmd_src,
    input  logic [11:0]       cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              src_rd,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [31:0]       src_rdata,
    ppu_vblank_dma_if.master  ppu,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int SUM_W = ((LEN_W > 12) ? LEN_W : 12) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_irq_q;
    logic [SRC_AW-1:0] r_src_ptr;
    logic [11:0]       r_dst_ptr;
    logic [LEN_W-1:0]  r_rd_left;
    logic [LEN_W-1:0]  r_wr_left;
    logic [31:0]       r_fifo [2];
    logic              r_wr_idx;
    logic              r_rd_idx;
    logic [1:0]        r_occ;
    logic              r_inflight;
    logic [11:0]       r_addr_hold;
    logic [31:0]       r_data_hold;
    logic              r_done;
    logic              r_err;

    logic [SUM_W-1:0]  w_end;
    logic              w_idle_cmd;
    logic              w_reject;
    logic              w_empty_cmd;
    logic              w_start;
    logic              w_rise;
    logic              w_pop;
    logic [2:0]        w_pending;
    logic              w_rd_ok;
    logic              w_src_rd;
    logic              w_last;

    // The 13-bit sum lets dst+len land exactly on 4096 without wrapping.
    assign w_end       = SUM_W'(cmd_dst) + SUM_W'(cmd_len);
    assign w_idle_cmd  = cmd_valid && (r_state == ST_IDLE);
    assign w_reject    = w_idle_cmd && (w_end > SUM_W'(4096));
    assign w_empty_cmd = w_idle_cmd && !w_reject && (cmd_len == '0);
    assign w_start     = w_idle_cmd && !w_reject && (cmd_len != '0);

    assign w_rise    = ppu.irq && !r_irq_q;
    assign w_pop     = (r_state == ST_RUN) && ppu.irq && (r_occ != 2'd0);
    assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_ok   = ppu.irq && (r_rd_left != '0) && (w_pending < 3'd2);
    assign w_last    = w_pop && (r_wr_left == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_rd    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_ARM;
            end
            // Only a fresh rising edge starts a transfer, never a vblank already under way.
            ST_ARM: begin
                if (w_rise) begin
                    w_state_nxt = ST_RUN;
                    w_src_rd    = w_rd_ok;
                end
            end
            ST_RUN: begin
                w_src_rd = w_rd_ok;
                if (w_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_q     <= 1'b0;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_rd_left   <= '0;
            r_wr_left   <= '0;
            r_wr_idx    <= 1'b0;
            r_rd_idx    <= 1'b0;
            r_occ       <= 2'd0;
            r_inflight  <= 1'b0;
            r_addr_hold <= '0;
            r_data_hold <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_irq_q    <= ppu.irq;
            r_done     <= w_empty_cmd || w_last;
            r_err      <= w_reject;
            r_inflight <= w_src_rd;
            r_occ      <= r_occ + 2'(r_inflight) - 2'(w_pop);

            if (w_start) begin
                r_src_ptr <= cmd_src;
                r_dst_ptr <= cmd_dst;
                r_rd_left <= cmd_len;
                r_wr_left <= cmd_len;
            end else if (w_src_rd) begin
                r_src_ptr <= r_src_ptr + SRC_AW'(1);
                r_rd_left <= r_rd_left - LEN_W'(1);
            end

            if (r_inflight) r_wr_idx <= ~r_wr_idx;

            if (w_pop) begin
                r_dst_ptr   <= r_dst_ptr + 12'd1;
                r_wr_left   <= r_wr_left - LEN_W'(1);
                r_rd_idx    <= ~r_rd_idx;
                r_addr_hold <= r_dst_ptr;
                r_data_hold <= r_fifo[r_rd_idx];
            end
        end
    end

    // NOTE: FIFO storage is deliberately not reset; r_occ gates every read of it.
    always_ff @(posedge clk) begin
        if (r_inflight) r_fifo[r_wr_idx] <= src_rdata;
    end

    assign cmd_ready      = (r_state == ST_IDLE);
    assign busy           = (r_state != ST_IDLE);
    assign done           = r_done;
    assign err            = r_err;
    assign src_rd         = w_src_rd;
    assign src_addr       = r_src_ptr;
    assign ppu.write      = w_pop;
    assign ppu.chipselect = w_pop;
    assign ppu.address    = w_pop ? r_dst_ptr : r_addr_hold;
    assign ppu.write_data = w_pop ? r_fifo[r_rd_idx] : r_data_hold;

endmodule

// File: tb/tb_ppu_vblank_dma.sv
// Directed bench for ppu_vblank_dma: source RAM model, bus monitor, immediate-assertion checks.
module tb_ppu_vblank_dma;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_src;
    logic [11:0] cmd_dst;
    logic [11:0] cmd_len;
    logic        src_rd;
    logic [8:0]  src_addr;
    logic [31:0] src_rdata;
    logic        busy;
    logic        done;
    logic        err;

    ppu_vblank_dma_if ppu_bus ();

    ppu_vblank_dma #(.SRC_AW(9), .LEN_W(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .src_rd    (src_rd),
        .src_addr  (src_addr),
        .src_rdata (src_rdata),
        .ppu       (ppu_bus.master),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source RAM word i holds 0xA000_0000 | i, returned one cycle after the read strobe.
    always @(posedge clk) begin
        if (src_rd) src_rdata <= 32'hA000_0000 | {23'd0, src_addr};
    end

    logic [11:0] wa_q [$];
    logic [31:0] wd_q [$];
    longint      wt_q [$];
    int          n_src_rd  = 0;
    int          n_done    = 0;
    int          n_err     = 0;
    int          n_bad_irq = 0;
    int          n_bad_cs  = 0;
    longint      last_done_t = 0;

    always @(negedge clk) begin
        if (ppu_bus.write === 1'b1) begin
            wa_q.push_back(ppu_bus.address);
            wd_q.push_back(ppu_bus.write_data);
            wt_q.push_back(longint'($time));
            if (ppu_bus.irq !== 1'b1) n_bad_irq++;
        end
        if (ppu_bus.write !== ppu_bus.chipselect) n_bad_cs++;
        if (src_rd === 1'b1) n_src_rd++;
        if (done === 1'b1) begin
            n_done++;
            last_done_t = longint'($time);
        end
        if (err === 1'b1) n_err++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [8:0] src, input logic [11:0] dst, input logic [11:0] len);
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int start_done, input int budget, input string tag);
        int k = 0;
        while (n_done == start_done && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, 64'(n_done != start_done), 64'd1);
    endtask

    task automatic wait_writes(input int target, input int budget, input string tag);
        int k = 0;
        while (wa_q.size() < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, 64'(wa_q.size() >= target), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int     base;
        int     d0;
        int     rd0;
        longint rise_t;

        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_src     = '0;
        cmd_dst     = '0;
        cmd_len     = '0;
        ppu_bus.irq = 1'b0;
        tick(2);

        // Reset state
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_write", ppu_bus.write, 0);
        check("rst_src_rd", src_rd, 0);
        check("rst_address", ppu_bus.address, 0);
        check("rst_wdata", ppu_bus.write_data, 0);
        check("rst_src_addr", src_addr, 0);
        tick(1);
        reset = 1'b0;
        tick(1);

        // Basic 4-word copy
        base = wa_q.size();
        rd0  = n_src_rd;
        d0   = n_done;
        send(9'h010, 12'h200, 12'd4);
        @(negedge clk);
        check("t1_busy", busy, 1);
        check("t1_cmd_ready", cmd_ready, 0);
        tick(3);
        check("t1_no_early_write", wa_q.size(), base);
        ppu_bus.irq = 1'b1;
        @(negedge clk);
        rise_t = longint'($time);
        check("t1_first_rd", src_rd, 1);
        check("t1_first_rd_addr", src_addr, 9'h010);
        wait_done(d0, 20, "t1_done_timeout");
        check("t1_nwrites", wa_q.size(), base + 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1_addr%0d", k), wa_q[base+k], 12'h200 + 12'(k));
            check($sformatf("t1_data%0d", k), wd_q[base+k], 32'hA000_0010 + 32'(k));
            check($sformatf("t1_time%0d", k), wt_q[base+k], rise_t + 20 + 10 * longint'(k));
        end
        check("t1_done_time", last_done_t, rise_t + 60);
        check("t1_nreads", n_src_rd - rd0, 4);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_ready", cmd_ready, 1);
        check("t1_hold_addr", ppu_bus.address, 12'h203);
        check("t1_hold_data", ppu_bus.write_data, 32'hA000_0013);
        tick(1);
        ppu_bus.irq = 1'b0;
        tick(2);

        // irq already high at accept: must wait for the next rising edge
        ppu_bus.irq = 1'b1;
        tick(2);
        base = wa_q.size();
        rd0  = n_src_rd;
        d0   = n_done;
        send(9'h020, 12'h010, 12'd2);
        tick(6);
        check("t2_no_write_in_tail", wa_q.size(), base);
        check("t2_no_read_in_tail", n_src_rd, rd0);
        check("t2_still_busy", busy, 1);
        ppu_bus.irq = 1'b0;
        tick(2);
        ppu_bus.irq = 1'b1;
        wait_done(d0, 20, "t2_done_timeout");
        check("t2_nwrites", wa_q.size(), base + 2);
        check("t2_addr0", wa_q[base], 12'h010);
        check("t2_data1", wd_q[base+1], 32'hA000_0021);
        tick(1);
        ppu_bus.irq = 1'b0;
        tick(2);

        // 8 words with a 20-cycle vblank gap after the third write
        base = wa_q.size();
        d0   = n_done;
        send(9'h040, 12'h300, 12'd8);
        tick(2);
        ppu_bus.irq = 1'b1;
        wait_writes(base + 3, 20, "t3_three_timeout");
        @(posedge clk);
        #1;
        ppu_bus.irq = 1'b0;
        tick(20);
        check("t3_pause_writes", wa_q.size(), base + 3);
        check("t3_pause_busy", busy, 1);
        ppu_bus.irq = 1'b1;
        wait_done(d0, 30, "t3_done_timeout");
        check("t3_nwrites", wa_q.size(), base + 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t3_addr%0d", k), wa_q[base+k], 12'h300 + 12'(k));
            check($sformatf("t3_data%0d", k), wd_q[base+k], 32'hA000_0040 + 32'(k));
        end
        check("t3_no_write_irq_low", n_bad_irq, 0);
        check("t3_cs_eq_write", n_bad_cs, 0);
        tick(1);
        ppu_bus.irq = 1'b0;
        tick(2);

        // Out-of-range destination is rejected
        base = wa_q.size();
        rd0  = n_src_rd;
        send(9'h000, 12'hFFE, 12'd3);
        @(negedge clk);
        check("t4_err_pulse", err, 1);
        check("t4_err_busy", busy, 0);
        check("t4_err_ready", cmd_ready, 1);
        tick(1);
        ppu_bus.irq = 1'b1;
        @(negedge clk);
        check("t4_err_one_cycle", err, 0);
        tick(4);
        check("t4_no_reads", n_src_rd, rd0);
        check("t4_no_writes", wa_q.size(), base);
        ppu_bus.irq = 1'b0;
        tick(2);

        // Destination ending exactly at 0xFFF is accepted
        base = wa_q.size();
        d0   = n_done;
        send(9'h080, 12'hFFD, 12'd3);
        tick(2);
        ppu_bus.irq = 1'b1;
        wait_done(d0, 20, "t5_done_timeout");
        check("t5_nwrites", wa_q.size(), base + 3);
        check("t5_last_addr", wa_q[base+2], 12'hFFF);
        check("t5_last_data", wd_q[base+2], 32'hA000_0082);
        tick(1);
        ppu_bus.irq = 1'b0;
        tick(2);

        // Zero-length command
        base = wa_q.size();
        rd0  = n_src_rd;
        send(9'h000, 12'h100, 12'd0);
        @(negedge clk);
        check("t6_done_pulse", done, 1);
        check("t6_busy", busy, 0);
        tick(1);
        @(negedge clk);
        check("t6_done_one_cycle", done, 0);
        check("t6_no_reads", n_src_rd, rd0);
        check("t6_no_writes", wa_q.size(), base);
        tick(1);

        // Commands offered while busy are ignored
        base = wa_q.size();
        d0   = n_done;
        send(9'h090, 12'h050, 12'd2);
        cmd_src   = 9'h1F0;
        cmd_dst   = 12'h600;
        cmd_len   = 12'd5;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("t7_ready_low", cmd_ready, 0);
        tick(3);
        cmd_valid = 1'b0;
        ppu_bus.irq = 1'b1;
        wait_done(d0, 20, "t7_done_timeout");
        tick(4);
        check("t7_nwrites", wa_q.size(), base + 2);
        check("t7_last_addr", wa_q[base+1], 12'h051);
        check("t7_last_data", wd_q[base+1], 32'hA000_0091);
        check("t7_one_done", n_done, d0 + 1);
        ppu_bus.irq = 1'b0;
        tick(2);

        // Reset in the middle of a transfer
        base = wa_q.size();
        send(9'h0A0, 12'h400, 12'd8);
        tick(2);
        ppu_bus.irq = 1'b1;
        wait_writes(base + 2, 20, "t8_two_timeout");
        @(posedge clk);
        #1;
        reset = 1'b1;
        d0 = n_done;
        tick(1);
        @(negedge clk);
        check("t8_rst_write", ppu_bus.write, 0);
        check("t8_rst_busy", busy, 0);
        check("t8_rst_ready", cmd_ready, 1);
        check("t8_rst_src_rd", src_rd, 0);
        check("t8_rst_address", ppu_bus.address, 0);
        tick(1);
        reset = 1'b0;
        tick(5);
        check("t8_no_done", n_done, d0);
        ppu_bus.irq = 1'b0;
        tick(1);
        base = wa_q.size();
        send(9'h030, 12'h020, 12'd1);
        tick(2);
        ppu_bus.irq = 1'b1;
        wait_done(d0, 20, "t8_new_done_timeout");
        check("t8_new_nwrites", wa_q.size(), base + 1);
        check("t8_new_addr", wa_q[base], 12'h020);
        check("t8_new_data", wd_q[base], 32'hA000_0030);
        check("end_no_write_irq_low", n_bad_irq, 0);
        check("end_err_count", n_err, 1);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
